mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single 32-bit memory port (address/data_out/data_in/write_enable/data_size) between
//  NUM_REQ requesters (Core fetch/load/store, debug loader, DMA). Round-robin arbitration,
//  one outstanding transaction at a time, fixed-latency read return. Sits between requesters and the RAM.
// PARAMETERS
//  NUM_REQ       2   number of requesters (>=2); index 0 is the Core
//  READ_LATENCY  1   cycles (>=1) from mem_address issue to mem_data_in valid
// PORTS
//  clk               in   1           system clock, all logic on posedge
//  rst               in   1           synchronous, active-high reset
//  req               in   NUM_REQ     request valid, held until gnt
//  req_address       in   32*NUM_REQ  byte address, packed, slot i = [32*i +: 32]
//  req_data_out      in   32*NUM_REQ  write data, packed
//  req_write_enable  in   NUM_REQ     1 = write, 0 = read
//  req_data_size     in   2*NUM_REQ   00 byte, 01 half, 10/11 word
//  gnt               out  NUM_REQ     one-cycle pulse: request accepted (onehot0)
//  rvalid            out  NUM_REQ     one-cycle pulse: transaction complete (onehot0)
//  rdata             out  32          read data, valid with rvalid; 0 for writes
//  busy              out  1           high in every state except ARB_IDLE
//  mem_address       out  32          to memory
//  mem_data_out      out  32          to memory
//  mem_write_enable  out  1           to memory
//  mem_data_size     out  2           to memory
//  mem_data_in       in   32          from memory
// BEHAVIOUR
//  - Reset: state ARB_IDLE; gnt/rvalid 0; rdata, mem_address, mem_data_out 0; mem_write_enable 0;
//    mem_data_size 2'b10; last_grant = NUM_REQ-1, so requester 0 wins the first tie.
//  - FSM: ARB_IDLE -> ARB_ISSUE -> (read: ARB_WAIT x READ_LATENCY) -> ARB_RESP -> ARB_IDLE.
//  - ARB_IDLE: if |req, pick the winner by round-robin starting at (last_grant+1) mod NUM_REQ.
//    Latch the winner's address/data/we/size and index, update last_grant, go ARB_ISSUE.
//    req is sampled only in ARB_IDLE.
//  - ARB_ISSUE (1 cycle): gnt[winner]=1. Drive mem_* from the latched fields.
//    mem_write_enable = latched we for this cycle only. Write -> ARB_RESP; read -> ARB_WAIT.
//  - ARB_WAIT: down-counter loaded with READ_LATENCY-1; mem_address/size held stable.
//    On the final WAIT edge, capture mem_data_in into rdata.
//  - ARB_RESP (1 cycle): rvalid[winner]=1, rdata = captured word (writes: 0) -> ARB_IDLE.
//  - Latency, with req sampled in cycle t: gnt at t+1; write rvalid at t+2; read rvalid at t+2+READ_LATENCY.
//  - No data_size extension or alignment: rdata is the raw mem_data_in word; requester extends.
//  - mem_address/mem_data_out/mem_data_size keep their last value in IDLE/RESP.
//    mem_write_enable is 0 outside ARB_ISSUE.
//  - Requests asserted while busy wait; a req dropped before being sampled in ARB_IDLE is never granted.
//  - Simultaneous reqs: round-robin order guarantees service within NUM_REQ-1 transactions of becoming eligible.
//  - rst mid-transaction: at the next edge all outputs take reset values; the transaction is aborted
//    with no rvalid; last_grant resets.
//  - Only the winner's bit may be set in gnt/rvalid; both are never high in the same cycle.
// STRUCTURE
//  - Package mem_arb_pkg: typedef enum arb_state_t {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP};
//    constants DS_BYTE=2'b00, DS_HALF=2'b01, DS_WORD=2'b10.
//  - Sub-module rr_priority_picker: combinational; inputs req and last_grant,
//    outputs onehot grant and index. Reusable elsewhere.
//  - Top level holds the FSM, latch registers, latency counter and output registers.
// TESTING
//  1. Read: req[0], address 0x100, size 10, READ_LATENCY=1, mem returns 0xDEADBEEF
//     -> gnt[0] at t+1, mem_address=0x100, rvalid[0] at t+3, rdata=0xDEADBEEF.
//  2. Write: req[1], we=1, address 0x20, data 0x55, size 00
//     -> mem_write_enable high exactly 1 cycle with 0x20/0x55/00; rvalid[1] at t+2; rdata=0.
//  3. Both req high from reset, held -> grant order 0,1,0,1; gnt onehot; no cycle with two rvalid bits.
//  4. req[0] held continuously, req[1] raised mid-read -> req[1] granted immediately after the current transaction.
//  5. rst asserted in ARB_WAIT -> next cycle busy=0, no rvalid ever, mem_write_enable=0, mem_data_size=10.
//  6. READ_LATENCY=3 read of 0x40 -> mem_address stable t+1..t+4, rvalid at t+5 with the sampled word.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter and its requesters.
package mem_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_t;

  localparam logic [1:0] DS_BYTE = 2'b00;
  localparam logic [1:0] DS_HALF = 2'b01;
  localparam logic [1:0] DS_WORD = 2'b10;
endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: the first requester after last_grant wins.
module rr_priority_picker #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);
  logic w_found;
  int   w_c;

  always_comb begin
    grant   = '0;
    index   = '0;
    w_found = 1'b0;
    w_c     = 0;
    // Scan starting one past the previous winner, wrapping; last_grant itself is checked last.
    for (int k = 1; k <= N; k++) begin
      w_c = (int'(last_grant) + k) % N;
      if (!w_found && req[w_c]) begin
        w_found     = 1'b1;
        grant[w_c]  = 1'b1;
        index       = IW'(w_c);
      end
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one 32-bit memory port among NUM_REQ requesters,
// one transaction in flight, fixed read latency.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [32*NUM_REQ-1:0]  req_address,
  input  logic [32*NUM_REQ-1:0]  req_data_out,
  input  logic [NUM_REQ-1:0]     req_write_enable,
  input  logic [2*NUM_REQ-1:0]   req_data_size,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     rvalid,
  output logic [31:0]            rdata,
  output logic                   busy,
  output logic [31:0]            mem_address,
  output logic [31:0]            mem_data_out,
  output logic                   mem_write_enable,
  output logic [1:0]             mem_data_size,
  input  logic [31:0]            mem_data_in
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  arb_state_t         r_state, w_next_state;
  logic [IW-1:0]      r_last_grant, r_idx;
  logic               r_we;
  logic [CW-1:0]      r_cnt;
  logic [31:0]        r_mem_address, r_mem_data_out, r_rdata;
  logic [1:0]         r_mem_size;
  logic               r_mem_we;
  logic [NUM_REQ-1:0] w_pick_gnt;
  logic [IW-1:0]      w_pick_idx;

  rr_priority_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req        (req),
    .last_grant (r_last_grant),
    .grant      (w_pick_gnt),
    .index      (w_pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ARB_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE:  if (|w_pick_gnt) w_next_state = ARB_ISSUE;
      ARB_ISSUE: w_next_state = r_we ? ARB_RESP : ARB_WAIT;
      ARB_WAIT:  if (r_cnt == '0) w_next_state = ARB_RESP;
      ARB_RESP:  w_next_state = ARB_IDLE;
      default:   w_next_state = ARB_IDLE;
    endcase
  end

  // The winner's fields go straight into the mem_* registers so they are on the port during ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant   <= IW'(NUM_REQ - 1);
      r_idx          <= '0;
      r_we           <= 1'b0;
      r_cnt          <= '0;
      r_mem_address  <= '0;
      r_mem_data_out <= '0;
      r_mem_size     <= DS_WORD;
      r_mem_we       <= 1'b0;
      r_rdata        <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          r_mem_we <= 1'b0;
          if (|w_pick_gnt) begin
            r_idx          <= w_pick_idx;
            r_last_grant   <= w_pick_idx;
            r_we           <= req_write_enable[w_pick_idx];
            r_mem_we       <= req_write_enable[w_pick_idx];
            r_mem_address  <= req_address[32*w_pick_idx +: 32];
            r_mem_data_out <= req_data_out[32*w_pick_idx +: 32];
            r_mem_size     <= req_data_size[2*w_pick_idx +: 2];
          end
        end
        ARB_ISSUE: begin
          r_mem_we <= 1'b0;
          r_cnt    <= CW'(READ_LATENCY - 1);
          if (r_we) r_rdata <= '0;
        end
        ARB_WAIT: begin
          if (r_cnt == '0) r_rdata <= mem_data_in;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt    = '0;
    rvalid = '0;
    if (r_state == ARB_ISSUE) gnt[r_idx]    = 1'b1;
    if (r_state == ARB_RESP)  rvalid[r_idx] = 1'b1;
  end

  assign busy             = (r_state != ARB_IDLE);
  assign rdata            = r_rdata;
  assign mem_address      = r_mem_address;
  assign mem_data_out     = r_mem_data_out;
  assign mem_write_enable = r_mem_we;
  assign mem_data_size    = r_mem_size;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table on a READ_LATENCY=1 instance plus
// corner sequences, and a READ_LATENCY=3 instance for the long-read case.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: READ_LATENCY=1
  logic [N-1:0]    a_req, a_we_in, a_gnt, a_rvalid;
  logic [32*N-1:0] a_addr, a_dout;
  logic [2*N-1:0]  a_size;
  logic [31:0]     a_rdata, a_mem_address, a_mem_data_out, a_mem_data_in;
  logic            a_busy, a_mem_we;
  logic [1:0]      a_mem_size;

  // Instance B: READ_LATENCY=3
  logic [N-1:0]    b_req, b_we_in, b_gnt, b_rvalid;
  logic [32*N-1:0] b_addr, b_dout;
  logic [2*N-1:0]  b_size;
  logic [31:0]     b_rdata, b_mem_address, b_mem_data_out, b_mem_data_in;
  logic            b_busy, b_mem_we;
  logic [1:0]      b_mem_size;

  mem_port_arbiter #(.NUM_REQ(N), .READ_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .req(a_req), .req_address(a_addr), .req_data_out(a_dout),
    .req_write_enable(a_we_in), .req_data_size(a_size), .gnt(a_gnt), .rvalid(a_rvalid),
    .rdata(a_rdata), .busy(a_busy), .mem_address(a_mem_address), .mem_data_out(a_mem_data_out),
    .mem_write_enable(a_mem_we), .mem_data_size(a_mem_size), .mem_data_in(a_mem_data_in)
  );

  mem_port_arbiter #(.NUM_REQ(N), .READ_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .req(b_req), .req_address(b_addr), .req_data_out(b_dout),
    .req_write_enable(b_we_in), .req_data_size(b_size), .gnt(b_gnt), .rvalid(b_rvalid),
    .rdata(b_rdata), .busy(b_busy), .mem_address(b_mem_address), .mem_data_out(b_mem_data_out),
    .mem_write_enable(b_mem_we), .mem_data_size(b_mem_size), .mem_data_in(b_mem_data_in)
  );

  // Memory content model: fixed word at 0x100, otherwise {addr[15:0], ~addr[15:0]}
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  logic [31:0] a_apipe;
  logic [31:0] b_apipe [3];
  always @(posedge clk) begin
    a_apipe    <= a_mem_address;
    b_apipe[0] <= b_mem_address;
    b_apipe[1] <= b_apipe[0];
    b_apipe[2] <= b_apipe[1];
  end
  assign a_mem_data_in = memf(a_apipe);
  assign b_mem_data_in = memf(b_apipe[2]);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard for instance A: push on grant from the bench's own request fields, pop on rvalid
  typedef struct {int idx; logic [31:0] rdata;} exp_t;
  exp_t sbq[$];

  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      sbq.delete();
    end else begin
      if (|a_gnt) begin
        chk("gnt_onehot", 32'($onehot(a_gnt)), 32'd1);
        for (int i = 0; i < N; i++)
          if (a_gnt[i]) begin
            exp_t e;
            e.idx   = i;
            e.rdata = a_we_in[i] ? 32'h0 : memf(a_addr[32*i +: 32]);
            sbq.push_back(e);
          end
      end
      if (|a_rvalid) begin
        chk("rvalid_onehot", 32'($onehot(a_rvalid)), 32'd1);
        chk("gnt_rvalid_overlap", 32'(a_gnt), 32'd0);
        if (sbq.size() == 0) begin
          chk("rvalid_unexpected", 32'(a_rvalid), 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_rvalid_idx", 32'(a_rvalid), 32'(1 << e.idx));
          chk("sb_rdata", a_rdata, e.rdata);
        end
      end
    end
  end

  typedef struct {
    int          idx;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  task automatic set_slot(input int i, input logic we, input logic [31:0] ad,
                          input logic [31:0] d, input logic [1:0] sz);
    a_we_in[i]         = we;
    a_addr[32*i +: 32] = ad;
    a_dout[32*i +: 32] = d;
    a_size[2*i +: 2]   = sz;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  // One isolated transaction on instance A with latency and port checks
  task automatic run_vec(input vec_t v);
    int n = 0;
    int we_extra = 0;
    bit got = 0;
    @(negedge clk);
    set_slot(v.idx, v.we, v.addr, v.data, v.size);
    a_req = '0;
    a_req[v.idx] = 1'b1;
    while (n < 20 && !got) begin
      @(negedge clk); n++;
      if (a_gnt[v.idx]) got = 1;
    end
    chk("gnt_latency", 32'(n), 32'd1);
    chk("mem_address", a_mem_address, v.addr);
    chk("mem_data_out", a_mem_data_out, v.data);
    chk("mem_data_size", 32'(a_mem_size), 32'(v.size));
    chk("mem_we_issue", 32'(a_mem_we), 32'(v.we));
    a_req[v.idx] = 1'b0;
    got = 0;
    while (n < 30 && !got) begin
      @(negedge clk); n++;
      if (a_mem_we) we_extra++;
      if (a_rvalid[v.idx]) got = 1;
    end
    chk("mem_we_pulse", 32'(we_extra), 32'd0);
    chk("rvalid_latency", 32'(n), 32'(v.exp_lat));
    chk("rdata", a_rdata, v.exp_rdata);
  endtask

  vec_t vecs[6];
  int   order[$];

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    a_req = '0; a_we_in = '0; a_addr = '0; a_dout = '0; a_size = '0;
    b_req = '0; b_we_in = '0; b_addr = '0; b_dout = '0; b_size = '0;

    vecs[0] = '{0, 1'b0, 32'h0000_0100, 32'h0,         DS_WORD, 32'hDEADBEEF, 3};
    vecs[1] = '{1, 1'b1, 32'h0000_0020, 32'h0000_0055, DS_BYTE, 32'h0,        2};
    vecs[2] = '{0, 1'b1, 32'h0000_0044, 32'hCAFEF00D,  DS_HALF, 32'h0,        2};
    vecs[3] = '{1, 1'b0, 32'h0000_1234, 32'h0,         DS_HALF, 32'h1234EDCB, 3};
    vecs[4] = '{0, 1'b0, 32'h8000_0004, 32'h0,         DS_BYTE, 32'h0004FFFB, 3};
    vecs[5] = '{1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, DS_WORD, 32'h0,        2};

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_gnt", 32'(a_gnt), 32'd0);
    chk("rst_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_rdata", a_rdata, 32'd0);
    chk("rst_mem_address", a_mem_address, 32'd0);
    chk("rst_mem_data_out", a_mem_data_out, 32'd0);
    chk("rst_mem_we", 32'(a_mem_we), 32'd0);
    chk("rst_mem_size", 32'(a_mem_size), 32'(DS_WORD));
    chk("rst_busy", 32'(a_busy), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Both requesters held from reset: strict alternation starting at 0
    @(negedge clk); rst = 1'b1;
    set_slot(0, 1'b0, 32'h100, 32'h0, DS_WORD);
    set_slot(1, 1'b0, 32'h200, 32'h0, DS_WORD);
    a_req = 2'b11;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (a_gnt[i]) order.push_back(i);
    end
    a_req = '0;
    chk("rr_grant_count", 32'(order.size()), 32'd4);
    for (int k = 0; k < 4 && k < order.size(); k++) chk("rr_order", 32'(order[k]), 32'(k % 2));
    repeat (10) @(negedge clk);
    chk("rr_drained", 32'(sbq.size()), 32'd0);

    // req[0] held, req[1] raised during the read: 1 must be next
    do_reset();
    begin
      int nxt = -1;
      set_slot(0, 1'b0, 32'h300, 32'h0, DS_WORD);
      set_slot(1, 1'b0, 32'h400, 32'h0, DS_WORD);
      a_req = 2'b01;
      for (int c = 0; c < 20 && !a_gnt[0]; c++) @(negedge clk);
      chk("hold_first_gnt", 32'(a_gnt), 32'b01);
      @(negedge clk);
      a_req[1] = 1'b1;
      for (int c = 0; c < 20 && nxt < 0; c++) begin
        @(negedge clk);
        if (a_gnt[1]) nxt = 1; else if (a_gnt[0]) nxt = 0;
      end
      a_req = '0;
      chk("late_req_next_winner", 32'(nxt), 32'd1);
      repeat (10) @(negedge clk);
    end

    // Reset while waiting on a read: abort without rvalid
    begin
      int c = 0;
      set_slot(0, 1'b0, 32'h500, 32'h0, DS_HALF);
      a_req = 2'b01;
      while (c < 20 && !a_gnt[0]) begin @(negedge clk); c++; end
      a_req = '0;
      @(negedge clk);
      chk("abort_in_wait_busy", 32'(a_busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", 32'(a_busy), 32'd0);
      chk("abort_rvalid", 32'(a_rvalid), 32'd0);
      chk("abort_mem_we", 32'(a_mem_we), 32'd0);
      chk("abort_mem_size", 32'(a_mem_size), 32'(DS_WORD));
      chk("abort_mem_address", a_mem_address, 32'd0);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("abort_no_pending", 32'(sbq.size()), 32'd0);
      // last_grant reset: requester 0 wins a tie again
      a_req = 2'b11;
      c = 0;
      while (c < 20 && !(|a_gnt)) begin @(negedge clk); c++; end
      a_req = '0;
      chk("abort_tie_winner", 32'(a_gnt), 32'b01);
      repeat (6) @(negedge clk);
    end

    // READ_LATENCY=3 read of 0x40 on instance B
    begin
      int n = 0;
      bit got = 0;
      @(negedge clk);
      b_addr[31:0] = 32'h40;
      b_size[1:0]  = DS_WORD;
      b_we_in[0]   = 1'b0;
      b_req[0]     = 1'b1;
      while (n < 20 && !got) begin
        @(negedge clk); n++;
        if (n == 1) begin
          chk("rl3_gnt", 32'(b_gnt), 32'b01);
          b_req[0] = 1'b0;
        end
        if (n <= 4) chk("rl3_addr_stable", b_mem_address, 32'h40);
        if (b_rvalid[0]) got = 1;
      end
      chk("rl3_rvalid_latency", 32'(n), 32'd5);
      chk("rl3_rdata", b_rdata, 32'h0040FFBF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
